// File: rtl/router_port_arbiter.sv
// router_port_arbiter: round-robin arbiter sharing one router output port
// among NREQ input-FIFO heads, with a registered word held until acked.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   req_i      per-requester FIFO non-empty
//   req_dat_i  packed head words, requester r at [r*(DW+3) +: DW+3]
//   pop_o      one-hot pop strobe to the winning FIFO (combinational)
//   dat_o      registered word offered to the device
//   validrx_o  dat_o is valid
//   ackrx_i    device accepts dat_o
//   gnt_o      one-hot owner of the word on dat_o
//   cnt_o      delivered-word count, saturating
//   drop_o     one-cycle pulse when a word is discarded on timeout
//
// Optional: define ARB_TIMEOUT_EN to drop an un-acked word after TMO
// cycles in OFFER. Without it OFFER waits forever and drop_o is 0.
module router_port_arbiter #(
  parameter int DW   = 4,
  parameter int NREQ = 3,
  parameter int TMO  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*(DW+3)-1:0] req_dat_i,
  output logic [NREQ-1:0]        pop_o,
  output logic [DW+2:0]          dat_o,
  output logic                   validrx_o,
  input  logic                   ackrx_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [15:0]            cnt_o,
  output logic                   drop_o
);

  localparam int WW = DW + 3;
  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TMO < 2) begin : g_bad_cfg
    $error("router_port_arbiter: unsupported NREQ or TMO");
  end

  typedef enum logic {
    IDLE,
    OFFER
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   dat_q, dat_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            any;
  logic            found;
  logic [PW:0]     idx;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            expire;
  logic            done;
  logic            grant;

  // Scan from ptr upward with an explicit wrap, so NREQ need not
  // be a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_i[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign any = |req_i;

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // An ack in the expiry cycle wins: the word is delivered, not dropped.
  assign expire = (state_q == OFFER) && !ackrx_i
                  && (tmo_q == TW'(TMO - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (grant || done) tmo_d = '0;
    else if (state_q == OFFER) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign expire = 1'b0;
`endif

  assign done  = (state_q == OFFER) && (ackrx_i || expire);
  assign grant = any && ((state_q == IDLE) || done);

  // Pop is suppressed during reset so no word is lost to a grant
  // that reset is about to discard.
  assign pop_o  = (grant && !rst_i) ? win_oh : '0;
  assign drop_o = expire && !rst_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dat_d   = dat_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (state_q == OFFER && ackrx_i && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
    if (grant) begin
      state_d = OFFER;
      dat_d   = req_dat_i[int'(win)*WW +: WW];
      gnt_d   = win_oh;
      vld_d   = 1'b1;
      ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else if (done) begin
      state_d = IDLE;
      gnt_d   = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dat_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dat_q   <= dat_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dat_o     = dat_q;
  assign gnt_o     = gnt_q;
  assign validrx_o = vld_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// tb_router_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_router_port_arbiter;

  localparam int DW   = 4;
  localparam int NREQ = 3;
  localparam int TMO  = 16;
  localparam int WW   = DW + 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*WW-1:0]   rdat;
  logic                 ack;
  logic [NREQ-1:0]      pop;
  logic [WW-1:0]        dat;
  logic                 vld;
  logic [NREQ-1:0]      gnt;
  logic [15:0]          cnt;
  logic                 drop;

  int n_chk = 0;
  int n_err = 0;

  // Model: is a word held, who owns it, what it is, rotation start.
  bit          m_busy;
  int          m_own;
  int          m_ptr;
  logic [WW-1:0] m_dat;
  int          m_cnt;
  int          m_wait;

  logic [NREQ-1:0] last_pop;
  logic            last_drop;

  router_port_arbiter #(.DW(DW), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .req_dat_i (rdat),
    .pop_o     (pop),
    .dat_o     (dat),
    .validrx_o (vld),
    .ackrx_i   (ack),
    .gnt_o     (gnt),
    .cnt_o     (cnt),
    .drop_o    (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic r, input logic [NREQ-1:0] rq,
                      input logic [NREQ*WW-1:0] rd, input logic ak);
    int  w;
    bit  tmo_hit;
    bit  fin;
    bit  take;
    @(negedge clk);
    rst = r; req = rq; rdat = rd; ack = ak;
    #1;
    w = pick(rq);
    tmo_hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_hit = m_busy && !ak && (m_wait == TMO - 1);
`endif
    fin  = m_busy && (ak || tmo_hit);
    take = (!m_busy || fin) && (w >= 0);
    check("pop", pop, (!r && take) ? oh(w) : '0);
    check("drop", drop, !r && tmo_hit);
    last_pop  = pop;
    last_drop = drop;
    if (r) begin
      m_busy = 0; m_own = -1; m_ptr = 0;
      m_dat = '0; m_cnt = 0; m_wait = 0;
    end else begin
      if (m_busy && ak && m_cnt < 65535) m_cnt++;
      if (take) begin
        m_busy = 1; m_own = w; m_ptr = (w + 1) % NREQ;
        m_dat  = rd[w*WW +: WW]; m_wait = 0;
      end else if (fin) begin
        m_busy = 0; m_own = -1; m_wait = 0;
      end else if (m_busy) begin
        m_wait++;
      end
    end
    @(posedge clk);
    #1;
    check("validrx", vld, m_busy);
    check("gnt", gnt, oh(m_own));
    check("dat", dat, m_dat);
    check("cnt", cnt, m_cnt);
  endtask

  initial begin
    logic [NREQ*WW-1:0] w5a;
    logic [NREQ-1:0]    seq [7];
    int npop;
    int ack_pct;
    int hit;

    rst = 1'b1; req = '0; rdat = '0; ack = 1'b0;
    m_busy = 0; m_own = -1; m_ptr = 0; m_dat = '0;
    m_cnt = 0; m_wait = 0;

    // Reset, then a single request from requester 1.
    step(1'b1, '0, '0, 1'b0);
    check("rst_vld", vld, 1'b0);
    check("rst_cnt", cnt, 16'd0);
    w5a = '0;
    w5a[1*WW +: WW] = 7'h5A;
    step(1'b0, 3'b010, w5a, 1'b0);
    check("s1_pop", last_pop, 3'b010);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0);
    check("s1_dat", dat, 7'h5A);
    step(1'b0, '0, '0, 1'b1);
    check("s1_cnt", cnt, 16'd1);
    check("s1_idle", vld, 1'b0);

    // Back-pressure from IDLE with ptr at 2: one pop in 10 cycles.
    npop = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b111, NREQ*WW'($urandom), 1'b0);
      if (i == 0) check("s1_next", last_pop, 3'b100);
      npop += $countones(last_pop);
    end
    check("bp_pops", npop, 1);

    // Fairness with everyone requesting and acking every cycle.
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    step(1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 3'b111, NREQ*WW'($urandom), 1'b1);
      check("rr_gnt", gnt, seq[i]);
    end
    check("rr_cnt", cnt, 16'd6);

    // Wrap and skip: ptr=2, requester 2 idle.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 3'b010, NREQ*WW'($urandom), 1'b0);
    step(1'b0, 3'b011, NREQ*WW'($urandom), 1'b1);
    check("wrap0", last_pop, 3'b001);
    step(1'b0, 3'b011, NREQ*WW'($urandom), 1'b1);
    check("wrap1", last_pop, 3'b010);
    step(1'b0, '0, '0, 1'b1);

    // Reset in the middle of an offer.
    step(1'b0, 3'b100, NREQ*WW'($urandom), 1'b0);
    step(1'b1, 3'b100, NREQ*WW'($urandom), 1'b0);
    check("mid_vld", vld, 1'b0);
    check("mid_gnt", gnt, 3'b000);
    check("mid_cnt", cnt, 16'd0);
    step(1'b0, 3'b111, NREQ*WW'($urandom), 1'b0);
    check("mid_ptr", last_pop, 3'b001);

`ifdef ARB_TIMEOUT_EN
    // Stuck ack: drop exactly TMO cycles after the grant.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 3'b001, NREQ*WW'($urandom), 1'b0);
    hit = 0;
    for (int i = 1; i <= TMO + 4; i++) begin
      step(1'b0, '0, '0, 1'b0);
      if (last_drop && hit == 0) hit = i;
    end
    check("tmo_at", hit, TMO);
    check("tmo_cnt", cnt, 16'd0);
    check("tmo_idle", vld, 1'b0);
`else
    hit = 0;
`endif

    // Randomized traffic with varying device back-pressure.
    ack_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 3;
          1:       ack_pct = 50;
          default: ack_pct = 95;
        endcase
      end
      step($urandom_range(0, 99) == 0,
           NREQ'($urandom),
           NREQ*WW'($urandom),
           $urandom_range(0, 99) < ack_pct);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Round-robin arbiter that shares one router output port among NREQ input-FIFO heads.
- Inside the router, one instance sits per output port (AX, AY, BX, BY), between the per-source FIFOs and the device-facing validrx/ackrx/dat_o interface.
- Captures the winning {adr,dat} word into an output register and pops the winner's FIFO.
- Holds the word on dat_o with validrx_o until the device acks, and supports back-to-back transfers.

Parameters:
- DW, 4, data width; the port word is DW+3 bits ({adr[2:0], dat[DW-1:0]}).
- NREQ, 3, number of requesters, 2..8.
- TMO, 16, ack timeout in clk_i cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  router clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NREQ  requester r's FIFO is non-empty.
- req_dat_i  in  NREQ*(DW+3)  head words; requester r occupies bits [r*(DW+3) +: DW+3].
- pop_o  out  NREQ  one-cycle pop strobe to the winning FIFO.
- dat_o  out  DW+3  registered word offered to the device.
- validrx_o  out  1  dat_o is valid.
- ackrx_i  in  1  device accepts dat_o; synchronous to clk_i.
- gnt_o  out  NREQ  one-hot owner of the word currently on dat_o.
- cnt_o  out  16  words delivered (acked), saturating at 16'hFFFF.
- drop_o  out  1  one-cycle pulse when a word is discarded on timeout.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State=IDLE, ptr=0.
  - pop_o=0, dat_o=0, validrx_o=0, gnt_o=0, cnt_o=0, drop_o=0, timeout counter=0.
  - Reset mid-OFFER discards the held word; its FIFO was already popped and the loss is accepted.
- Selection (combinational):
  - Winner w = first r with req_i[r]=1, scanning r = ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - "any" = |req_i.
- Grant event (same cycle):
  - pop_o[w]=1, combinational from state and selection.
  - At the edge: dat_o<=req_dat_i[w], gnt_o<=onehot(w), validrx_o<=1, ptr<=(w+1 mod NREQ), state<=OFFER.
  - Latency: req_i rising in cycle N gives pop_o in N and validrx_o in N+1.
- IDLE:
  - If any: grant event.
  - Otherwise hold, with validrx_o=0 and gnt_o=0.
- OFFER:
  - dat_o, gnt_o and validrx_o are stable while ackrx_i=0.
  - ackrx_i=1 and any: cnt_o increments; grant event in the same cycle (back-to-back, 1 word/cycle). validrx_o stays 1 and dat_o updates at the edge.
  - ackrx_i=1 and no requests: cnt_o increments; state<=IDLE, validrx_o<=0, gnt_o<=0. dat_o keeps its last value.
- ackrx_i while validrx_o=0 is ignored.
- Requester changes:
  - req_i or req_dat_i changing after grant does not affect the held word.
  - A requester that drops req_i before selection is skipped.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,…,NREQ-1 with no requester granted twice before all others.
- Width rules:
  - ptr is $clog2(NREQ) bits; wrap from NREQ-1 to 0 is explicit (no power-of-2 assumption).
  - cnt_o saturates and never wraps.
- pop_o is never asserted for a requester with req_i=0, and never more than one bit at a time.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every grant event and increments each OFFER cycle with ackrx_i=0.
  - When it reaches TMO-1 with ackrx_i=0: the word is dropped, drop_o pulses for 1 cycle, cnt_o does not increment.
  - The FSM then proceeds exactly as the ack path: grant the next requester if any, else IDLE.
  - ackrx_i=1 in the same cycle as expiry counts as an ack, with no drop.
- Without the macro: OFFER waits indefinitely, drop_o is tied 0, and no counter is synthesized.

Test Plan (defaults DW=4, NREQ=3, TMO=16):
- Reset then single request: req_i=3'b010, word 7'h5A; ackrx_i high 3 cycles later → pop_o=3'b010 for 1 cycle; dat_o=7'h5A with validrx_o=1 held 3 cycles; cnt_o=1; IDLE after; next ptr=2.
- All requesting, ackrx_i=1 continuously: gnt_o sequence 001,010,100,001,…; validrx_o continuously 1 after the first cycle; cnt_o=6 after 6 acked words.
- Back-pressure: ackrx_i=0 for 10 cycles while req_i=3'b111 → dat_o/gnt_o unchanged; only 1 pop total; no further pops until ack.
- Wrap/skip: ptr=2, req_i=3'b011 → winner 0 then 1, requester 2 skipped.
- Reset mid-OFFER (validrx_o=1, rst_i pulsed 1 cycle) → next cycle validrx_o=0, gnt_o=0, cnt_o=0, ptr=0.
- ARB_TIMEOUT_EN defined, ackrx_i stuck 0, req_i=3'b001 then 0 → drop_o pulses exactly 16 cycles after grant; cnt_o stays 0; IDLE.
